gol_vram_blitter: RTL and testbench

Upstream feeder for the VGA text-mode Avalon interface. Consumes a Game-of-Life cell stream, two cells per beat, in raster order. Packs each pair into one 32-bit VRAM word (two glyph halves) and writes the frame into text VRAM through an Avalon-MM master port. Frame writes start on the falling edge of VGA vsync so software and display stay frame-aligned.

---
 rtl/gol_vram_blitter_pkg.sv | 55 +++++
 rtl/gol_vram_blitter_if.sv | 18 +
 rtl/gol_vram_blitter_vs_sync.sv | 24 ++
 rtl/gol_vram_blitter.sv | 147 ++++++++++++++
 tb/tb_gol_vram_blitter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gol_vram_blitter_pkg.sv
// Shared types and constants for the Game-of-Life VRAM blitter.
// GOL_BLIT_PALETTE_INIT_EN adds the palette-load state and its colour table.
package gol_blit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef GOL_BLIT_PALETTE_INIT_EN
    ST_PAL,
`endif
    ST_WAIT_VS,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  // Address bit 13 selects the target region on the text-mode slave
  localparam logic VRAM_SEL = 1'b0;
  localparam logic PAL_SEL  = 1'b1;

  typedef struct packed {
    logic       iv;
    logic [6:0] code;
    logic [3:0] fg;
    logic [3:0] bg;
  } glyph_half_t;

`ifdef GOL_BLIT_PALETTE_INIT_EN
  localparam int unsigned PAL_WORDS = 16;

  // 12-bit RGB in the low bits, CGA-like ordering
  localparam logic [15:0] GOL_PALETTE [PAL_WORDS] = '{
    16'h0000, 16'h000A, 16'h00A0, 16'h00AA,
    16'h0A00, 16'h0A0A, 16'h0A50, 16'h0AAA,
    16'h0555, 16'h055F, 16'h05F5, 16'h05FF,
    16'h0F55, 16'h0F5F, 16'h0FF5, 16'h0FFF
  };
`endif

  function automatic glyph_half_t make_half(
    input logic       alive,
    input logic [6:0] a_code,
    input logic [3:0] a_fg,
    input logic [3:0] a_bg,
    input logic [6:0] d_code,
    input logic [3:0] d_fg,
    input logic [3:0] d_bg
  );
    glyph_half_t h;
    h.iv   = 1'b0;
    h.code = alive ? a_code : d_code;
    h.fg   = alive ? a_fg   : d_fg;
    h.bg   = alive ? a_bg   : d_bg;
    return h;
  endfunction

endpackage

// File: rtl/gol_vram_blitter_if.sv
// Avalon-MM write-only master bus between the blitter and the text-mode VRAM.
interface gol_vram_blitter_if;
  logic [13:0] M_ADDR;
  logic        M_WRITE;
  logic [3:0]  M_BYTEEN;
  logic [31:0] M_WRITEDATA;
  logic        M_WAITREQUEST;

  modport master (
    output M_ADDR, M_WRITE, M_BYTEEN, M_WRITEDATA,
    input  M_WAITREQUEST
  );

  modport slave (
    input  M_ADDR, M_WRITE, M_BYTEEN, M_WRITEDATA,
    output M_WAITREQUEST
  );
endinterface

// File: rtl/gol_vram_blitter_vs_sync.sv
// Brings VGA vsync into the system clock domain and flags its falling edge.
module gol_vs_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vs_async,
  output logic vs_fall_c
);

  logic [1:0] sync;
  logic       vs_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      vs_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], vs_async};
      vs_prev <= sync[1];
    end
  end

  assign vs_fall_c = vs_prev & ~sync[1];

endmodule

// File: rtl/gol_vram_blitter.sv
// Packs a Game-of-Life cell-pair stream into text VRAM words, one frame per START,
// aligned to VGA vsync. Define GOL_BLIT_PALETTE_INIT_EN to load the palette first.
module gol_vram_blitter
  import gol_blit_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [6:0]         ALIVE_CODE,
  input  logic [6:0]         DEAD_CODE,
  input  logic [3:0]         ALIVE_FG,
  input  logic [3:0]         ALIVE_BG,
  input  logic [3:0]         DEAD_FG,
  input  logic [3:0]         DEAD_BG,
  input  logic               CELL_VALID,
  output logic               CELL_READY,
  input  logic [1:0]         CELL_PAIR,
  input  logic               VS_ASYNC,
  gol_vram_blitter_if.master avm,
  output logic               BUSY,
  output logic               DONE,
  output logic [15:0]        FRAME_CNT
);

  localparam int unsigned WORDS = COLS * ROWS / 2;
  localparam int unsigned IDX_W = 13;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             m_write;
  logic [13:0]      m_addr;
  logic [3:0]       m_byteen;
  logic [31:0]      m_wdata;
  logic             vs_fall_c;
  logic             accept_c;
  logic             cell_hs_c;
  logic [31:0]      pair_word_c;
`ifdef GOL_BLIT_PALETTE_INIT_EN
  logic [4:0]       pal_cnt;
`endif

  gol_vs_sync u_vs_sync (
    .clk      (CLK),
    .rst_n    (RESET),
    .vs_async (VS_ASYNC),
    .vs_fall_c(vs_fall_c)
  );

  assign avm.M_WRITE     = m_write;
  assign avm.M_ADDR      = m_addr;
  assign avm.M_BYTEEN    = m_byteen;
  assign avm.M_WRITEDATA = m_wdata;

  // A new word may be loaded whenever the output register is empty or draining this cycle
  assign accept_c   = m_write & ~avm.M_WAITREQUEST;
  assign CELL_READY = (state == ST_STREAM) & (~m_write | ~avm.M_WAITREQUEST);
  assign cell_hs_c  = CELL_VALID & CELL_READY;

  assign pair_word_c = {
    make_half(CELL_PAIR[1], ALIVE_CODE, ALIVE_FG, ALIVE_BG, DEAD_CODE, DEAD_FG, DEAD_BG),
    make_half(CELL_PAIR[0], ALIVE_CODE, ALIVE_FG, ALIVE_BG, DEAD_CODE, DEAD_FG, DEAD_BG)
  };

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      idx       <= '0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_byteen  <= 4'b1111;
      m_wdata   <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FRAME_CNT <= '0;
`ifdef GOL_BLIT_PALETTE_INIT_EN
      pal_cnt   <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      if (accept_c) m_write <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (START) begin
`ifdef GOL_BLIT_PALETTE_INIT_EN
            state   <= ST_PAL;
            pal_cnt <= '0;
`else
            state   <= ST_WAIT_VS;
`endif
            BUSY <= 1'b1;
            idx  <= '0;
          end
        end

`ifdef GOL_BLIT_PALETTE_INIT_EN
        // Entry 2i+h goes to palette word i, half h
        ST_PAL: begin
          if (!m_write || accept_c) begin
            if (pal_cnt != 5'(PAL_WORDS)) begin
              m_write  <= 1'b1;
              m_addr   <= {PAL_SEL, 10'd0, pal_cnt[3:1]};
              m_byteen <= pal_cnt[0] ? 4'b1100 : 4'b0011;
              m_wdata  <= pal_cnt[0] ? {GOL_PALETTE[pal_cnt[3:0]], 16'h0000}
                                     : {16'h0000, GOL_PALETTE[pal_cnt[3:0]]};
              pal_cnt  <= pal_cnt + 5'd1;
            end else begin
              state <= ST_WAIT_VS;
            end
          end
        end
`endif

        ST_WAIT_VS: begin
          if (vs_fall_c) state <= ST_STREAM;
        end

        ST_STREAM: begin
          if (cell_hs_c) begin
            m_write  <= 1'b1;
            m_addr   <= {VRAM_SEL, idx};
            m_byteen <= 4'b1111;
            m_wdata  <= pair_word_c;
            idx      <= idx + 1'b1;
            if (idx == LAST_IDX) state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (accept_c) begin
            DONE      <= 1'b1;
            FRAME_CNT <= FRAME_CNT + 16'd1;
            BUSY      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_vram_blitter.sv
// Directed-plus-random bench for gol_vram_blitter on a 4x2 cell frame (4 VRAM words).
`ifdef GOL_BLIT_PALETTE_INIT_EN
import gol_blit_pkg::*;
`endif

module tb_gol_vram_blitter;

  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int WORDS = COLS * ROWS / 2;
`ifdef GOL_BLIT_PALETTE_INIT_EN
  localparam int NPAL     = 16;
  localparam int PRE_WAIT = 60;
`else
  localparam int NPAL     = 0;
  localparam int PRE_WAIT = 6;
`endif

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET, START, CELL_VALID, CELL_READY, VS_ASYNC, BUSY, DONE;
  logic [6:0]  ALIVE_CODE, DEAD_CODE;
  logic [3:0]  ALIVE_FG, ALIVE_BG, DEAD_FG, DEAD_BG;
  logic [1:0]  CELL_PAIR;
  logic [15:0] FRAME_CNT;

  gol_vram_blitter_if av ();

  gol_vram_blitter #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .ALIVE_CODE(ALIVE_CODE), .DEAD_CODE(DEAD_CODE),
    .ALIVE_FG(ALIVE_FG), .ALIVE_BG(ALIVE_BG), .DEAD_FG(DEAD_FG), .DEAD_BG(DEAD_BG),
    .CELL_VALID(CELL_VALID), .CELL_READY(CELL_READY), .CELL_PAIR(CELL_PAIR),
    .VS_ASYNC(VS_ASYNC), .avm(av),
    .BUSY(BUSY), .DONE(DONE), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int passed = 0, total = 0;
  int cyc = 0, frames_done = 0;
  int done_cnt = 0, done_cyc = 0, first_wr_cyc = -1, stall2_cnt = 0, fall_cyc = 0;
  int wr_mode = 0, hold_left = 0;
  bit hold_done = 0;
  wr_t cap_q[$];
  wr_t exp_q[$];
  logic [1:0] pairs [WORDS];

  bit          prev_stall = 0;
  logic [13:0] p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Slave side: waitrequest off, random, held 5 cycles on word 2, or stuck high
  initial begin
    av.M_WAITREQUEST = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (wr_mode)
        0: av.M_WAITREQUEST = 1'b0;
        1: av.M_WAITREQUEST = ($urandom_range(0, 2) == 0);
        2: begin
          if (hold_left > 0) begin
            av.M_WAITREQUEST = 1'b1;
            hold_left = hold_left - 1;
          end else if (av.M_WRITE && av.M_ADDR == 14'd2 && !hold_done) begin
            av.M_WAITREQUEST = 1'b1;
            hold_left = 4;
            hold_done = 1;
          end else begin
            av.M_WAITREQUEST = 1'b0;
          end
        end
        default: av.M_WAITREQUEST = 1'b1;
      endcase
    end
  end

  // Bus monitor: capture accepted writes and check the stall hold rule
  always @(negedge CLK) begin
    if (!RESET) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_write", 32'(av.M_WRITE), 32'd1);
        check("hold_addr", 32'(av.M_ADDR), 32'(p_addr));
        check("hold_data", av.M_WRITEDATA, p_data);
        check("hold_be", 32'(av.M_BYTEEN), 32'(p_be));
      end
      if (av.M_WRITE && av.M_WAITREQUEST) check("ready_in_stall", 32'(CELL_READY), 32'd0);
      if (av.M_WRITE && !av.M_WAITREQUEST)
        cap_q.push_back('{addr: av.M_ADDR, data: av.M_WRITEDATA, be: av.M_BYTEEN, cyc: cyc + 1});
      if (av.M_WRITE && !av.M_ADDR[13] && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (av.M_WRITE && av.M_WAITREQUEST && av.M_ADDR == 14'd2) stall2_cnt = stall2_cnt + 1;
      if (DONE) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      prev_stall = av.M_WRITE && av.M_WAITREQUEST;
      p_addr = av.M_ADDR;
      p_data = av.M_WRITEDATA;
      p_be   = av.M_BYTEEN;
    end
  end

  function automatic int half_m(input bit alive);
    if (alive) return int'(ALIVE_CODE) * 256 + int'(ALIVE_FG) * 16 + int'(ALIVE_BG);
    return int'(DEAD_CODE) * 256 + int'(DEAD_FG) * 16 + int'(DEAD_BG);
  endfunction

  function automatic int count_vram();
    int n = 0;
    foreach (cap_q[i]) if (!cap_q[i].addr[13]) n++;
    return n;
  endfunction

  task automatic build_expected();
    wr_t e;
    exp_q.delete();
`ifdef GOL_BLIT_PALETTE_INIT_EN
    for (int j = 0; j < 16; j++) begin
      e.addr = 14'h2000 + 14'(j / 2);
      e.be   = (j % 2 == 1) ? 4'hC : 4'h3;
      e.data = (j % 2 == 1) ? 32'(GOL_PALETTE[j]) * 65536 : 32'(GOL_PALETTE[j]);
      e.cyc  = 0;
      exp_q.push_back(e);
    end
`endif
    for (int k = 0; k < WORDS; k++) begin
      e.addr = 14'(k);
      e.be   = 4'hF;
      e.data = 32'(half_m(pairs[k][1])) * 65536 + 32'(half_m(pairs[k][0]));
      e.cyc  = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic random_cfg();
    ALIVE_CODE = 7'($urandom); DEAD_CODE = 7'($urandom);
    ALIVE_FG = 4'($urandom); ALIVE_BG = 4'($urandom);
    DEAD_FG = 4'($urandom); DEAD_BG = 4'($urandom);
    foreach (pairs[k]) pairs[k] = 2'($urandom);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic do_frame(input bit gaps, input bit extra_start, input bit coincide);
    int k, guard;
    bit hs;
    build_expected();
    cap_q.delete();
    done_cnt = 0; first_wr_cyc = -1; stall2_cnt = 0;
    if (coincide) begin
      // START lands in the same cycle as the synchronised vsync fall
      VS_ASYNC = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      pulse_start();
      VS_ASYNC = 1'b1;
    end else begin
      pulse_start();
    end
    CELL_VALID = 1'b1;
    CELL_PAIR  = 2'($urandom);
    repeat (PRE_WAIT) begin
      @(posedge CLK); #1;
      if (extra_start) START = ($urandom_range(0, 1) == 1);
    end
    START = 1'b0;
    @(negedge CLK);
    check("busy_before_vs", 32'(BUSY), 32'd1);
    check("ready_before_vs", 32'(CELL_READY), 32'd0);
    check("no_vram_before_vs", 32'(count_vram()), 32'd0);
    @(posedge CLK); #1;
    VS_ASYNC = 1'b0;
    fall_cyc = cyc;
    k = 0; guard = 0;
    while (k < WORDS && guard < 500) begin
      CELL_PAIR  = pairs[k];
      CELL_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge CLK);
      hs = CELL_VALID && CELL_READY;
      @(posedge CLK); #1;
      if (hs) k++;
      guard++;
    end
    check("feed_complete", 32'(k), 32'(WORDS));
    CELL_VALID = 1'b1;
    CELL_PAIR  = 2'($urandom);
    guard = 0;
    while (done_cnt == 0 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    repeat (4) @(posedge CLK);
    #1;
    VS_ASYNC = 1'b1;
    CELL_VALID = 1'b0;
    frames_done++;
    check("n_writes", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check("wr_addr", 32'(cap_q[i].addr), 32'(exp_q[i].addr));
      check("wr_data", cap_q[i].data, exp_q[i].data);
      check("wr_be", 32'(cap_q[i].be), 32'(exp_q[i].be));
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (cap_q.size() > 0) check("done_timing", 32'(done_cyc), 32'(cap_q[cap_q.size()-1].cyc));
    check("first_wr_after_vs", 32'(first_wr_cyc - fall_cyc >= 3), 32'd1);
    check("frame_cnt", 32'(FRAME_CNT), 32'(frames_done));
    check("busy_after", 32'(BUSY), 32'd0);
    if (!gaps && wr_mode == 0 && cap_q.size() == NPAL + WORDS)
      for (int i = 1; i < WORDS; i++)
        check("back_to_back", 32'(cap_q[NPAL+i].cyc), 32'(cap_q[NPAL].cyc + i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    RESET = 1'b0; START = 1'b0; VS_ASYNC = 1'b1; CELL_VALID = 1'b0; CELL_PAIR = 2'b00;
    ALIVE_CODE = 7'h7F; ALIVE_FG = 4'hA; ALIVE_BG = 4'h1;
    DEAD_CODE = 7'h20; DEAD_FG = 4'h0; DEAD_BG = 4'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_write", 32'(av.M_WRITE), 32'd0);
    check("rst_addr", 32'(av.M_ADDR), 32'd0);
    check("rst_data", av.M_WRITEDATA, 32'd0);
    check("rst_be", 32'(av.M_BYTEEN), 32'hF);
    check("rst_ready", 32'(CELL_READY), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    // Packing example, full-rate frame
    foreach (pairs[k]) pairs[k] = 2'($urandom);
    pairs[0] = 2'b01;
    wr_mode = 0;
    do_frame(1'b0, 1'b0, 1'b0);
    if (cap_q.size() > NPAL) begin
      check("pack_example", cap_q[NPAL].data, 32'h2000_7FA1);
      check("pack_addr0", 32'(cap_q[NPAL].addr), 32'd0);
    end

    // Waitrequest held 5 cycles on word 2
    random_cfg();
    wr_mode = 2; hold_done = 0; hold_left = 0;
    do_frame(1'b0, 1'b0, 1'b0);
    check("stall_word2_cycles", 32'(stall2_cnt), 32'd5);

    // Extra STARTs while busy, random stalls and valid gaps
    random_cfg();
    wr_mode = 1;
    do_frame(1'b1, 1'b1, 1'b0);

    // START coincident with vsync fall must wait for the next fall
    random_cfg();
    wr_mode = 0;
    do_frame(1'b0, 1'b0, 1'b1);

    for (int f = 0; f < 4; f++) begin
      random_cfg();
      wr_mode = (f % 2 == 0) ? 1 : 0;
      do_frame(f[0], f[1], 1'b0);
    end

    // Reset while a write is stalled: everything returns to idle, nothing resumes
    random_cfg();
    wr_mode = 0;
    pulse_start();
    repeat (PRE_WAIT) @(posedge CLK);
    #1;
    VS_ASYNC = 1'b0;
    wr_mode = 3;
    CELL_VALID = 1'b1;
    guard = 0;
    do begin
      @(negedge CLK);
      guard++;
    end while (!(av.M_WRITE && !av.M_ADDR[13]) && guard < 40);
    check("stall_reached", 32'(av.M_WRITE), 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("midrst_write", 32'(av.M_WRITE), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_ready", 32'(CELL_READY), 32'd0);
    check("midrst_frame_cnt", 32'(FRAME_CNT), 32'd0);
    check("midrst_done", 32'(DONE), 32'd0);
    RESET = 1'b1;
    wr_mode = 0;
    VS_ASYNC = 1'b1;
    cap_q.delete();
    repeat (20) @(posedge CLK);
    #1;
    check("no_recovery", 32'(cap_q.size()), 32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
